// File: rtl/npu_host_seq_pkg.sv
// npu_host_seq_pkg: shared sequencer constants, state encoding and config-word helper.
package npu_host_seq_pkg;

   localparam int BUS_W     = 32;
   localparam int WCNT_DEF  = 13;
   localparam int CALC_DEF  = 8;
   localparam int OFIFO_DEF = 32;
   localparam int CFG_WORDS = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CFG   = 3'd1,
      ST_WGT   = 3'd2,
      ST_INP   = 3'd3,
      ST_GAP   = 3'd4,
      ST_CALC  = 3'd5,
      ST_READ  = 3'd6,
      ST_DRAIN = 3'd7
   } seq_state_e;

   // Config word order on the npu bus: layers, in, h1, h2, out, act.
   function automatic logic [4:0] cfg_field(input logic [2:0] idx,
                                            input logic [1:0] layers,
                                            input logic [4:0] n_in,
                                            input logic [4:0] n_h1,
                                            input logic [4:0] n_h2,
                                            input logic [4:0] n_out,
                                            input logic [1:0] act);
      case (idx)
         3'd0:    cfg_field = {3'b000, layers};
         3'd1:    cfg_field = n_in;
         3'd2:    cfg_field = n_h1;
         3'd3:    cfg_field = n_h2;
         3'd4:    cfg_field = n_out;
         3'd5:    cfg_field = {3'b000, act};
         default: cfg_field = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/npu_host_seq_if.sv
// npu_host_seq_if: source stream, sink stream and npu word bus of the host sequencer.
interface npu_host_seq_if #(parameter int DATA_W = 32);
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic              src_ready;
   logic              snk_valid;
   logic [DATA_W-1:0] snk_data;
   logic              snk_ready;
   logic              npu_we;
   logic              npu_oe;
   logic [DATA_W-1:0] npu_data_o;
   logic              npu_data_drv;
   logic [DATA_W-1:0] npu_data_i;

   modport master (
      input  src_valid, src_data, snk_ready, npu_data_i,
      output src_ready, snk_valid, snk_data, npu_we, npu_oe, npu_data_o, npu_data_drv
   );

   modport slave (
      output src_valid, src_data, snk_ready, npu_data_i,
      input  src_ready, snk_valid, snk_data, npu_we, npu_oe, npu_data_o, npu_data_drv
   );
endinterface

// File: rtl/npu_host_seq_chk.sv
// npu_host_seq_chk: simulation checks on the output FIFO (no push when full, no pop when empty).
module npu_host_seq_chk (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty
);
   a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
endmodule

// File: rtl/npu_host_seq_fifo.sv
// npu_host_seq_fifo: synchronous FIFO holding captured npu output words until the sink takes them.
module npu_host_seq_fifo #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage array, written on push only.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= ptr_inc(wr_ptr_r);
         if (pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign pop_data = mem_r[rd_ptr_r];
   assign full     = (count_r == CNT_W'(DEPTH));
   assign empty    = (count_r == '0);
   assign count    = count_r;
endmodule

// File: rtl/npu_host_seq.sv
// npu_host_seq: streams a job (config, weights, inputs) onto the npu word bus, then captures and drains results.
// Optional perf counters perf_jobs/perf_stall are built when NPU_SEQ_PERF_EN is defined.
module npu_host_seq
   import npu_host_seq_pkg::*;
#(
   parameter int DATA_W  = BUS_W,
   parameter int WCNT_W  = WCNT_DEF,
   parameter int CALC_W  = CALC_DEF,
   parameter int OFIFO_D = OFIFO_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        cfg_num_layers,
   input  logic [4:0]        cfg_num_in,
   input  logic [4:0]        cfg_num_h1,
   input  logic [4:0]        cfg_num_h2,
   input  logic [4:0]        cfg_num_out,
   input  logic [1:0]        cfg_act,
   input  logic [WCNT_W-1:0] cfg_num_w,
   input  logic [CALC_W-1:0] cfg_num_calc,
   output logic              busy,
   output logic              done,
`ifdef NPU_SEQ_PERF_EN
   output logic [31:0]       perf_jobs,
   output logic [31:0]       perf_stall,
`endif
   npu_host_seq_if.master    bus
);
   localparam int CNT_W  = (WCNT_W > CALC_W) ? WCNT_W : CALC_W;
   localparam int FCNT_W = $clog2(OFIFO_D + 1);

   seq_state_e        state_r, next_state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, stream_last_s;
   logic [1:0]        layers_r, act_r;
   logic [4:0]        num_in_r, num_h1_r, num_h2_r, num_out_r;
   logic [WCNT_W-1:0] num_w_r;
   logic [CALC_W-1:0] num_calc_r;
   logic              busy_r, done_r, src_ready_r, we_r, oe_r, drv_r;
   logic [DATA_W-1:0] data_o_r, data_s;
   logic              we_s, oe_s, drv_s, done_s, xfer_s, pop_s, last_pop_s;
   logic              cap_valid_r;
   logic [DATA_W-1:0] cap_data_r, fifo_head_s;
   logic              fifo_full_s, fifo_empty_s;
   logic [FCNT_W-1:0] fifo_count_s;

   assign xfer_s        = bus.src_valid & src_ready_r;
   assign pop_s         = ~fifo_empty_s & bus.snk_ready;
   // Job is finished only once the capture pipe is empty and the final FIFO word leaves.
   assign last_pop_s    = pop_s & (fifo_count_s == FCNT_W'(1)) & ~cap_valid_r & ~oe_r;
   assign stream_last_s = (state_r == ST_WGT) ? (CNT_W'(num_w_r) - CNT_W'(1)) : CNT_W'(num_in_r);

   // Next-state, counter and bus-drive decode.
   always_comb begin
      next_state_s = state_r;
      cnt_nxt_s    = cnt_r;
      we_s         = 1'b0;
      oe_s         = 1'b0;
      drv_s        = 1'b0;
      done_s       = 1'b0;
      data_s       = '0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s = ST_CFG;
               cnt_nxt_s    = '0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_CFG: begin
            we_s   = 1'b1;
            drv_s  = 1'b1;
            data_s = DATA_W'(cfg_field(cnt_r[2:0], layers_r, num_in_r, num_h1_r,
                                       num_h2_r, num_out_r, act_r));
            if (cnt_r == CNT_W'(CFG_WORDS - 1)) begin
               cnt_nxt_s    = '0;
               next_state_s = (num_w_r == '0) ? ST_INP : ST_WGT;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_WGT, ST_INP: begin
            drv_s  = 1'b1;
            data_s = data_o_r;
            if (xfer_s) begin
               we_s   = 1'b1;
               data_s = bus.src_data;
               if (cnt_r == stream_last_s) begin
                  cnt_nxt_s    = '0;
                  next_state_s = (state_r == ST_WGT) ? ST_INP : ST_GAP;
               end else begin
                  cnt_nxt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               we_s = 1'b0;
            end
         end
         ST_GAP: begin
            cnt_nxt_s    = '0;
            next_state_s = (num_calc_r == '0) ? ST_READ : ST_CALC;
         end
         ST_CALC: begin
            if (cnt_r == CNT_W'(num_calc_r) - CNT_W'(1)) begin
               cnt_nxt_s    = '0;
               next_state_s = ST_READ;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_READ: begin
            oe_s = 1'b1;
            if (cnt_r == CNT_W'(num_out_r)) begin
               cnt_nxt_s    = '0;
               next_state_s = ST_DRAIN;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (last_pop_s) begin
               done_s       = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DRAIN;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State, counter and job shadow registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         layers_r   <= 2'd0;
         num_in_r   <= 5'd0;
         num_h1_r   <= 5'd0;
         num_h2_r   <= 5'd0;
         num_out_r  <= 5'd0;
         act_r      <= 2'd0;
         num_w_r    <= '0;
         num_calc_r <= '0;
      end else begin
         state_r <= next_state_s;
         cnt_r   <= cnt_nxt_s;
         if (state_r == ST_IDLE && start) begin
            layers_r   <= cfg_num_layers;
            num_in_r   <= cfg_num_in;
            num_h1_r   <= cfg_num_h1;
            num_h2_r   <= cfg_num_h2;
            num_out_r  <= cfg_num_out;
            act_r      <= cfg_act;
            num_w_r    <= cfg_num_w;
            num_calc_r <= cfg_num_calc;
         end
      end
   end

   // Registered status, handshake and npu bus outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         src_ready_r <= 1'b0;
         we_r        <= 1'b0;
         oe_r        <= 1'b0;
         drv_r       <= 1'b0;
         data_o_r    <= '0;
      end else begin
         busy_r      <= (next_state_s != ST_IDLE);
         done_r      <= done_s;
         src_ready_r <= (next_state_s == ST_WGT) || (next_state_s == ST_INP);
         we_r        <= we_s;
         oe_r        <= oe_s;
         drv_r       <= drv_s;
         data_o_r    <= data_s;
      end
   end

   // One-stage capture of npu_data_i while the npu is output-enabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_valid_r <= 1'b0;
         cap_data_r  <= '0;
      end else begin
         cap_valid_r <= oe_r;
         if (oe_r) cap_data_r <= bus.npu_data_i;
      end
   end

   npu_host_seq_fifo #(.DATA_W(DATA_W), .DEPTH(OFIFO_D)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (cap_valid_r),
      .push_data(cap_data_r),
      .pop      (pop_s),
      .pop_data (fifo_head_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s),
      .count    (fifo_count_s)
   );

   npu_host_seq_chk u_chk (
      .clk  (clk),
      .rst  (rst),
      .push (cap_valid_r),
      .pop  (pop_s),
      .full (fifo_full_s),
      .empty(fifo_empty_s)
   );

`ifdef NPU_SEQ_PERF_EN
   logic [31:0] perf_jobs_r, perf_stall_r;

   // Completed-job counter (wraps) and source-stall counter (saturates).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_jobs_r  <= 32'd0;
         perf_stall_r <= 32'd0;
      end else begin
         if (done_s) perf_jobs_r <= perf_jobs_r + 32'd1;
         if (src_ready_r && !bus.src_valid && perf_stall_r != 32'hFFFF_FFFF)
            perf_stall_r <= perf_stall_r + 32'd1;
      end
   end

   assign perf_jobs  = perf_jobs_r;
   assign perf_stall = perf_stall_r;
`endif

   assign busy             = busy_r;
   assign done             = done_r;
   assign bus.src_ready    = src_ready_r;
   assign bus.snk_valid    = ~fifo_empty_s;
   assign bus.snk_data     = fifo_head_s;
   assign bus.npu_we       = we_r;
   assign bus.npu_oe       = oe_r;
   assign bus.npu_data_drv = drv_r;
   assign bus.npu_data_o   = data_o_r;
endmodule

// File: tb/tb_npu_host_seq.sv
// tb_npu_host_seq: randomized scoreboard bench; reference model is per-job word lists and timing rules.
module tb_npu_host_seq;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  cfg_num_layers = 2'd0, cfg_act = 2'd0;
   logic [4:0]  cfg_num_in = 5'd0, cfg_num_h1 = 5'd0, cfg_num_h2 = 5'd0, cfg_num_out = 5'd0;
   logic [12:0] cfg_num_w = 13'd0;
   logic [7:0]  cfg_num_calc = 8'd0;
   logic        busy, done;
`ifdef NPU_SEQ_PERF_EN
   logic [31:0] perf_jobs, perf_stall;
`endif

   npu_host_seq_if #(.DATA_W(DW)) ifc();

   npu_host_seq dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_layers(cfg_num_layers), .cfg_num_in(cfg_num_in), .cfg_num_h1(cfg_num_h1),
      .cfg_num_h2(cfg_num_h2), .cfg_num_out(cfg_num_out), .cfg_act(cfg_act),
      .cfg_num_w(cfg_num_w), .cfg_num_calc(cfg_num_calc),
      .busy(busy), .done(done),
`ifdef NPU_SEQ_PERF_EN
      .perf_jobs(perf_jobs), .perf_stall(perf_stall),
`endif
      .bus(ifc)
   );

   always #5 clk = ~clk;

   typedef struct { int total_we; int calc; int nout; } job_t;

   int total = 0;
   int bad = 0;
   job_t job_q[$];
   logic [DW-1:0] exp_npu_q[$], exp_snk_q[$], npu_out_q[$], src_q[$];
   int cyc = 0, we_cnt = 0, last_we_cyc = 0, oe_len = 0, done_seen = 0, stall_seen = 0;
   bit busy_chk = 1'b0;
   bit hold_snk = 1'b0;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: npu write order, bus turnaround, calc gap, read length, sink words, done.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         we_cnt = 0;
         oe_len = 0;
         busy_chk = 1'b0;
      end else begin
         if (busy_chk) begin
            chk_eq("busy_after_done", busy, 1'b0);
            busy_chk = 1'b0;
         end
         if (job_q.size() > 0 && we_cnt == job_q[0].total_we)
            chk_eq("bus_released", ifc.npu_data_drv, 1'b0);
         if (ifc.npu_we) begin
            chk_eq("we_drv", ifc.npu_data_drv, 1'b1);
            if (exp_npu_q.size() > 0) chk_eq("npu_word", ifc.npu_data_o, exp_npu_q.pop_front());
            else chk_eq("npu_extra_we", ifc.npu_we, 1'b0);
            we_cnt++;
            last_we_cyc = cyc;
         end
         if (ifc.npu_oe) begin
            if (oe_len == 0 && job_q.size() > 0)
               chk_eq("calc_gap", cyc - last_we_cyc, job_q[0].calc + 2);
            oe_len++;
         end else if (oe_len > 0) begin
            if (job_q.size() > 0) chk_eq("oe_len", oe_len, job_q[0].nout + 1);
            oe_len = 0;
         end
         if (ifc.snk_valid && ifc.snk_ready) begin
            if (exp_snk_q.size() > 0) chk_eq("snk_word", ifc.snk_data, exp_snk_q.pop_front());
            else chk_eq("snk_extra", ifc.snk_valid, 1'b0);
         end
         if (done) begin
            done_seen++;
            if (job_q.size() > 0) begin
               chk_eq("we_total", we_cnt, job_q[0].total_we);
               void'(job_q.pop_front());
            end else chk_eq("done_extra", done, 1'b0);
            chk_eq("snk_all", exp_snk_q.size(), 0);
            we_cnt = 0;
            busy_chk = 1'b1;
         end
      end
   end

   // npu model returns queued result words while oe is high; sink readiness is random unless held.
   always @(posedge clk) begin
      #1;
      if (rst && ifc.npu_oe) begin
         if (npu_out_q.size() > 0) ifc.npu_data_i = npu_out_q.pop_front();
         else begin
            ifc.npu_data_i = DW'($urandom);
            chk_eq("oe_extra", ifc.npu_oe, 1'b0);
         end
      end else ifc.npu_data_i = DW'($urandom);
      ifc.snk_ready = hold_snk ? 1'b0 : (($urandom % 4) != 0);
   end

   task automatic feed(input int mode, input int limit);
      int cl = 0;
      int acc = 0;
      while (src_q.size() > 0 && acc != limit && cl < 4000) begin
         bit v;
         case (mode)
            1:       v = (cl % 3) != 2;
            2:       v = ($urandom % 10) >= 3;
            default: v = 1'b1;
         endcase
         ifc.src_valid = v;
         ifc.src_data  = v ? src_q[0] : DW'($urandom);
         @(negedge clk);
         if (ifc.src_ready) begin
            if (v) begin
               void'(src_q.pop_front());
               acc++;
            end else stall_seen++;
         end
         @(posedge clk);
         #1;
         cl++;
      end
      ifc.src_valid = 1'b0;
   endtask

   task automatic run_job(input logic [1:0] lay, input logic [4:0] nin, input logic [4:0] h1,
                          input logic [4:0] h2, input logic [4:0] nout, input logic [1:0] act,
                          input logic [12:0] nw, input logic [7:0] nc, input int mode,
                          input bit hold, input bit poke, input int abort_at);
      job_t j;
      int d0;
      int g;
      logic [DW-1:0] w;
      j.total_we = 6 + int'(nw) + int'(nin) + 1;
      j.calc = int'(nc);
      j.nout = int'(nout);
      job_q.push_back(j);
      exp_npu_q.push_back({30'd0, lay});
      exp_npu_q.push_back({27'd0, nin});
      exp_npu_q.push_back({27'd0, h1});
      exp_npu_q.push_back({27'd0, h2});
      exp_npu_q.push_back({27'd0, nout});
      exp_npu_q.push_back({30'd0, act});
      for (int i = 0; i < int'(nw) + int'(nin) + 1; i++) begin
         w = DW'($urandom);
         src_q.push_back(w);
         exp_npu_q.push_back(w);
      end
      for (int i = 0; i <= int'(nout); i++) begin
         w = DW'($urandom);
         npu_out_q.push_back(w);
         exp_snk_q.push_back(w);
      end
      d0 = done_seen;
      hold_snk = hold;
      cfg_num_layers = lay; cfg_num_in = nin; cfg_num_h1 = h1; cfg_num_h2 = h2;
      cfg_num_out = nout; cfg_act = act; cfg_num_w = nw; cfg_num_calc = nc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cfg_num_in = 5'($urandom); cfg_num_out = 5'($urandom);
      cfg_num_w = 13'($urandom); cfg_num_calc = 8'($urandom);
      chk_eq("busy_start", busy, 1'b1);
      if (abort_at >= 0) begin
         feed(mode, abort_at);
         #2 rst = 1'b0;
         #1;
         chk_eq("rst_we", ifc.npu_we, 1'b0);
         chk_eq("rst_drv", ifc.npu_data_drv, 1'b0);
         chk_eq("rst_busy", busy, 1'b0);
         chk_eq("rst_src_ready", ifc.src_ready, 1'b0);
         exp_npu_q.delete(); exp_snk_q.delete(); npu_out_q.delete(); src_q.delete(); job_q.delete();
         repeat (3) @(posedge clk);
         #1 rst = 1'b1;
         repeat (10) @(posedge clk);
         #1;
         chk_eq("rst_no_done", done_seen, d0);
         chk_eq("rst_idle_busy", busy, 1'b0);
         return;
      end
      fork
         feed(mode, -1);
         begin
            if (poke) begin
               repeat (3) @(posedge clk);
               #1 start = 1'b1;
               @(posedge clk);
               #1 start = 1'b0;
            end
         end
         begin
            if (hold) begin
               int gh = 0;
               while ((npu_out_q.size() > 0 || ifc.npu_oe) && gh < 3000) begin
                  @(posedge clk);
                  #1;
                  gh++;
               end
               repeat (4) @(posedge clk);
               #1;
               chk_eq("hold_snk_full", ifc.snk_valid, 1'b1);
               hold_snk = 1'b0;
            end
         end
      join
      g = 0;
      while (done_seen == d0 && g < 3000) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk_eq("done_count", done_seen, d0 + 1);
      repeat (3) @(posedge clk);
      #1;
      chk_eq("idle_busy", busy, 1'b0);
      chk_eq("queues_empty", exp_npu_q.size() + exp_snk_q.size(), 0);
   endtask

   initial begin
      int s0;
`ifdef NPU_SEQ_PERF_EN
      logic [31:0] ps0, pj0;
`endif
      ifc.src_valid = 1'b0;
      ifc.src_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("reset_busy", busy, 1'b0);
      chk_eq("reset_done", done, 1'b0);
      chk_eq("reset_src_ready", ifc.src_ready, 1'b0);
      chk_eq("reset_snk_valid", ifc.snk_valid, 1'b0);
      chk_eq("reset_we", ifc.npu_we, 1'b0);
      chk_eq("reset_oe", ifc.npu_oe, 1'b0);
      chk_eq("reset_drv", ifc.npu_data_drv, 1'b0);
      chk_eq("reset_data_o", ifc.npu_data_o, 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_job(2'd0, 5'd9, 5'd0, 5'd0, 5'd0, 2'd1, 13'd11, 8'd5, 0, 1'b0, 1'b0, -1);

      s0 = stall_seen;
`ifdef NPU_SEQ_PERF_EN
      ps0 = perf_stall;
      pj0 = perf_jobs;
`endif
      run_job(2'd0, 5'd9, 5'd0, 5'd0, 5'd0, 2'd1, 13'd11, 8'd5, 1, 1'b0, 1'b0, -1);
`ifdef NPU_SEQ_PERF_EN
      chk_eq("perf_stall", perf_stall - ps0, 32'(stall_seen - s0));
      chk_eq("perf_jobs", perf_jobs - pj0, 32'd1);
`endif

      run_job(2'd1, 5'd3, 5'd4, 5'd5, 5'd31, 2'd2, 13'd7, 8'd2, 2, 1'b1, 1'b0, -1);
      run_job(2'd0, 5'd4, 5'd0, 5'd0, 5'd2, 2'd0, 13'd0, 8'd0, 0, 1'b0, 1'b1, -1);
      run_job(2'd0, 5'd4, 5'd0, 5'd0, 5'd1, 2'd0, 13'd20, 8'd3, 0, 1'b0, 1'b0, 4);
      run_job(2'd0, 5'd9, 5'd0, 5'd0, 5'd0, 2'd1, 13'd11, 8'd5, 0, 1'b0, 1'b0, -1);

      for (int k = 0; k < 6; k++)
         run_job(2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 2'($urandom), 13'($urandom_range(0, 40)), 8'($urandom_range(0, 12)),
                 int'($urandom_range(0, 2)), 1'b0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
